// File: rtl/data_fetch_load_pkg.sv
// Shared types and helpers for the matrix load responder.
package data_fetch_pkg;

  localparam int MAX_ELEMS = 16;
  localparam int IDX_W     = $clog2(MAX_ELEMS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    DRAIN   = 2'd2,
    RELEASE = 2'd3
  } fetch_state_t;

  function automatic logic [2:0] dimen_to_n(input logic [1:0] dimen);
    return {1'b0, dimen} + 3'd1;
  endfunction

endpackage

// File: rtl/data_fetch_load_if.sv
// Control, memory and PE-side signals of the load responder in one bundle.
interface data_fetch_load_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [1:0]        DIMEN;
  logic              ADDR_START;
  logic              ADDR_RST;
  logic [3:0]        ADDRESS;
  logic              MEM_RD_EN;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_RDATA;
  logic [DATA_W-1:0] DATA_OUT;
  logic              DATA_VALID;
  logic [1:0]        ROW;
  logic [1:0]        COL;
  logic              FETCH_DONE;

  modport slave (
    input  DIMEN, ADDR_START, ADDR_RST, ADDRESS, MEM_RDATA,
    output MEM_RD_EN, MEM_ADDR, DATA_OUT, DATA_VALID, ROW, COL, FETCH_DONE
  );

  modport master (
    output DIMEN, ADDR_START, ADDR_RST, ADDRESS, MEM_RDATA,
    input  MEM_RD_EN, MEM_ADDR, DATA_OUT, DATA_VALID, ROW, COL, FETCH_DONE
  );
endinterface

// File: rtl/data_fetch_load_counter.sv
// Linear element index plus row/column counters for a row-major N x N walk.
module fetch_index_counter
  import data_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             enable,
  input  logic [2:0]       n,
  output logic [IDX_W-1:0] k,
  output logic [1:0]       row,
  output logic [1:0]       col,
  output logic             last
);

  logic [IDX_W-1:0] k_reg;
  logic [1:0]       row_reg;
  logic [1:0]       col_reg;
  logic             col_wrap;

  assign col_wrap = ({1'b0, col_reg} == (n - 3'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_reg   <= '0;
      row_reg <= '0;
      col_reg <= '0;
    end else if (load) begin
      k_reg   <= '0;
      row_reg <= '0;
      col_reg <= '0;
    end else if (enable) begin
      k_reg <= k_reg + 1'b1;
      if (col_wrap) begin
        col_reg <= '0;
        row_reg <= row_reg + 2'd1;
      end else begin
        col_reg <= col_reg + 2'd1;
      end
    end
  end

  assign k    = k_reg;
  assign row  = row_reg;
  assign col  = col_reg;
  assign last = col_wrap && ({1'b0, row_reg} == (n - 3'd1));

endmodule

// File: rtl/data_fetch_load.sv
// Load responder: reads an N x N matrix from block memory and streams it to the PEs.
module data_fetch_load
  import data_fetch_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int BLOCK_WORDS = 16
) (
  input logic               CLK,
  input logic               RSTN,
  data_fetch_load_if.slave  bus
);

  fetch_state_t      state_reg, state_next;
  logic [2:0]        n_reg;
  logic [ADDR_W-1:0] base_reg;
  logic              valid_reg;
  logic              done_reg;
  logic [1:0]        row_reg;
  logic [1:0]        col_reg;

  logic              start_ok;
  logic              rd_en;
  logic              cnt_load;
  logic              cnt_enable;
  logic [IDX_W-1:0]  cnt_k;
  logic [1:0]        cnt_row;
  logic [1:0]        cnt_col;
  logic              cnt_last;

  assign start_ok = bus.ADDR_START && !bus.ADDR_RST;

  fetch_index_counter u_index (
    .clk    (CLK),
    .rst_n  (RSTN),
    .load   (cnt_load),
    .enable (cnt_enable),
    .n      (n_reg),
    .k      (cnt_k),
    .row    (cnt_row),
    .col    (cnt_col),
    .last   (cnt_last)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (bus.ADDR_RST) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE:    if (bus.ADDR_START) state_next = READ;
        READ:    if (cnt_last) state_next = DRAIN;
        DRAIN:   state_next = RELEASE;
        RELEASE: if (!bus.ADDR_START) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // The counter holds the index being issued, so the address follows it directly.
  always_comb begin
    rd_en      = (state_reg == READ);
    cnt_load   = bus.ADDR_RST || ((state_reg == IDLE) && bus.ADDR_START);
    cnt_enable = rd_en;
  end

  assign bus.MEM_RD_EN = rd_en;
  assign bus.MEM_ADDR  = rd_en ? (base_reg + ADDR_W'(cnt_k)) : '0;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      n_reg    <= '0;
      base_reg <= '0;
    end else if ((state_reg == IDLE) && start_ok) begin
      n_reg    <= dimen_to_n(bus.DIMEN);
      base_reg <= ADDR_W'(BLOCK_WORDS * int'(bus.ADDRESS));
    end
  end

  // Beat k lines up with the memory's registered read of address base + k.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      row_reg   <= '0;
      col_reg   <= '0;
    end else begin
      valid_reg <= rd_en && !bus.ADDR_RST;
      done_reg  <= rd_en && cnt_last && !bus.ADDR_RST;
      row_reg   <= rd_en ? cnt_row : 2'd0;
      col_reg   <= rd_en ? cnt_col : 2'd0;
    end
  end

  assign bus.DATA_OUT   = valid_reg ? bus.MEM_RDATA : '0;
  assign bus.DATA_VALID = valid_reg;
  assign bus.FETCH_DONE = done_reg;
  assign bus.ROW        = row_reg;
  assign bus.COL        = col_reg;

endmodule

// File: tb/tb_data_fetch_load.sv
// Scoreboard bench: stimulus queues expected reads/beats, a negedge monitor checks them.
module tb_data_fetch_load;

  logic clk = 1'b0;
  logic rstn;
  int   vectors = 0;
  int   miscompares = 0;

  typedef struct {
    int data;
    int row;
    int col;
    int done;
  } beat_t;

  int    addr_q[$];
  beat_t beat_q[$];
  logic [7:0] mem [0:255];

  always #5 clk = ~clk;

  data_fetch_load_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  data_fetch_load #(.DATA_W(8), .ADDR_W(8), .BLOCK_WORDS(16)) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus)
  );

  always @(posedge clk) begin
    if (bus.MEM_RD_EN) bus.MEM_RDATA <= mem[bus.MEM_ADDR];
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.MEM_RD_EN) begin
        if (addr_q.size() == 0) begin
          check("unexpected_read", int'(bus.MEM_RD_EN), 0);
        end else begin
          int ea;
          ea = addr_q.pop_front();
          check("mem_addr", int'(bus.MEM_ADDR), ea);
          $display("read addr=%0d", bus.MEM_ADDR);
        end
      end
      if (bus.DATA_VALID) begin
        if (beat_q.size() == 0) begin
          check("unexpected_beat", int'(bus.DATA_VALID), 0);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          check("data_out", int'(bus.DATA_OUT), b.data);
          check("row", int'(bus.ROW), b.row);
          check("col", int'(bus.COL), b.col);
          check("fetch_done", int'(bus.FETCH_DONE), b.done);
          $display("beat data=%0d row=%0d col=%0d done=%0d", bus.DATA_OUT, bus.ROW, bus.COL, bus.FETCH_DONE);
        end
      end else begin
        check("done_without_valid", int'(bus.FETCH_DONE), 0);
      end
    end
  end

  // Reference: E = N*N elements at (ADDRESS*16 + k) mod 256, row-major index.
  task automatic push_model(input int dimen, input int address, input int na, input int nb, input bit with_done);
    int n, e, a;
    n = dimen + 1;
    e = n * n;
    for (int k = 0; k < na; k++) addr_q.push_back((address * 16 + k) % 256);
    for (int k = 0; k < nb; k++) begin
      a = (address * 16 + k) % 256;
      beat_q.push_back('{int'(mem[a]), k / n, k % n, (with_done && k == e - 1) ? 1 : 0});
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"}, int'(bus.MEM_RD_EN), 0);
    check({tag, "_mem_addr"}, int'(bus.MEM_ADDR), 0);
    check({tag, "_valid"}, int'(bus.DATA_VALID), 0);
    check({tag, "_done"}, int'(bus.FETCH_DONE), 0);
    check({tag, "_data"}, int'(bus.DATA_OUT), 0);
    check({tag, "_row"}, int'(bus.ROW), 0);
    check({tag, "_col"}, int'(bus.COL), 0);
  endtask

  task automatic run_fetch(input int dimen, input int address, input int abort_m, input int hold);
    int e, seen, lat;
    e = (dimen + 1) * (dimen + 1);
    if (abort_m >= 0) push_model(dimen, address, abort_m + 1, abort_m, 1'b0);
    else              push_model(dimen, address, e, e, 1'b1);
    @(posedge clk); #1;
    bus.DIMEN = 2'(dimen);
    bus.ADDRESS = 4'(address);
    bus.ADDR_START = 1'b1;
    @(posedge clk); #1;
    // Changes after the start edge must not affect the running fetch.
    bus.DIMEN = 2'($urandom);
    bus.ADDRESS = 4'($urandom);
    if (abort_m >= 0) begin
      repeat (abort_m) @(posedge clk);
      #1;
      bus.ADDR_RST = 1'b1;
      bus.ADDR_START = 1'b0;
      @(posedge clk); #1;
      bus.ADDR_RST = 1'b0;
      @(negedge clk);
      check("abort_rd_en", int'(bus.MEM_RD_EN), 0);
      check("abort_valid", int'(bus.DATA_VALID), 0);
      check("abort_done", int'(bus.FETCH_DONE), 0);
    end else begin
      seen = 0;
      lat = -1;
      for (int c = 0; c < 40 && seen == 0; c++) begin
        @(negedge clk);
        seen = int'(bus.FETCH_DONE);
        if (seen != 0) lat = c;
      end
      check("fetch_done_seen", seen, 1);
      check("fetch_latency", lat, e);
      repeat (hold) @(posedge clk);
      @(posedge clk); #1;
      bus.ADDR_START = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    bus.DIMEN = '0;
    bus.ADDR_START = 1'b0;
    bus.ADDR_RST = 1'b0;
    bus.ADDRESS = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(posedge clk); #3;
    rstn = 1'b1;

    mem[32] = 8'h5A;
    run_fetch(0, 2, -1, 0);

    for (int k = 0; k < 16; k++) mem[16 + k] = 8'(k);
    run_fetch(3, 1, -1, 0);

    run_fetch(2, 15, -1, 0);

    run_fetch(3, 0, 4, 0);
    run_fetch(3, 0, -1, 0);

    run_fetch(1, 3, -1, 4);
    run_fetch(1, 3, -1, 0);

    // Start and abort together: must stay idle.
    @(posedge clk); #1;
    bus.ADDR_START = 1'b1;
    bus.ADDR_RST = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("both_high_rd_en", int'(bus.MEM_RD_EN), 0);
    end
    @(posedge clk); #1;
    bus.ADDR_START = 1'b0;
    bus.ADDR_RST = 1'b0;

    // Asynchronous reset in the middle of a 4x4 read.
    push_model(3, 4, 16, 16, 1'b1);
    @(posedge clk); #1;
    bus.DIMEN = 2'd3;
    bus.ADDRESS = 4'd4;
    bus.ADDR_START = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #3;
    rstn = 1'b0;
    bus.ADDR_START = 1'b0;
    #1;
    check_idle_outputs("midread_reset");
    addr_q.delete();
    beat_q.delete();
    @(posedge clk); #3;
    rstn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_reset_valid", int'(bus.DATA_VALID), 0);
      check("post_reset_rd_en", int'(bus.MEM_RD_EN), 0);
    end

    for (int it = 0; it < 12; it++) begin
      int d, a, e, ab;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      d = $urandom_range(0, 3);
      a = $urandom_range(0, 15);
      e = (d + 1) * (d + 1);
      ab = -1;
      if (e > 1 && $urandom_range(0, 3) == 0) ab = $urandom_range(0, e - 2);
      run_fetch(d, a, ab, $urandom_range(0, 3));
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("addr_queue_empty", addr_q.size(), 0);
    check("beat_queue_empty", beat_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
